// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: access sizes, exception causes, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package lsu_ctrl_pkg;

   // Access size encodings as carried on req_size_i
   localparam logic [1:0] LSU_SZ_B = 2'd0;
   localparam logic [1:0] LSU_SZ_H = 2'd1;
   localparam logic [1:0] LSU_SZ_W = 2'd2;
   localparam logic [1:0] LSU_SZ_D = 2'd3;

   // Exception cause codes as reported on exc_cause_o
   localparam logic [1:0] LSU_EXC_NONE        = 2'd0;
   localparam logic [1:0] LSU_EXC_LD_MISALIGN = 2'd1;
   localparam logic [1:0] LSU_EXC_ST_MISALIGN = 2'd2;
   localparam logic [1:0] LSU_EXC_ACCESS      = 2'd3;

   typedef enum logic [2:0] {
      LSU_IDLE  = 3'd0,
      LSU_REQ   = 3'd1,
      LSU_WAIT  = 3'd2,
      LSU_REQ2  = 3'd3,
      LSU_WAIT2 = 3'd4,
      LSU_RESP  = 3'd5
   } lsu_state_e;

   // Byte-enable width for a given data width
   function automatic int lsu_be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Number of bytes touched by an access of the given size
   function automatic int unsigned lsu_size_bytes(input logic [1:0] size);
      return 32'd1 << size;
   endfunction

   // Address offset not a multiple of the access size
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
      logic mis;
      case (size)
         LSU_SZ_B: mis = 1'b0;
         LSU_SZ_H: mis = off[0];
         LSU_SZ_W: mis = |off[1:0];
         default:  mis = |off;
      endcase
      return mis;
   endfunction

   // Dword accesses only exist on a 64-bit bus
   function automatic logic lsu_size_illegal(input logic [1:0] size, input int data_w);
      return (size == LSU_SZ_D) && (data_w != 64);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables and store lane shift over a two-beat window, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: size_i/offset_i/unsigned_i describe the access; wdata_i is right-justified store data;
//        rdata_i is the two-beat read assembly {beat1, beat0}; be_o/wdata_o span both beats
//        (low half = first beat); rdata_o is the extended load result.
module lsu_align
   import lsu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int BE_W  = DATA_W / 8,
   localparam int OFF_W = $clog2(DATA_W / 8)
) (
   input  logic [1:0]          size_i,
   input  logic [OFF_W-1:0]    offset_i,
   input  logic                unsigned_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [2*DATA_W-1:0] rdata_i,
   output logic [2*BE_W-1:0]   be_o,
   output logic [2*DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [2*BE_W-1:0]   mask;
   logic [2*DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0]   raw;
   logic [DATA_W-1:0]   keep;
   logic                sbit;
   int unsigned         nbytes;

   always_comb begin
      nbytes   = lsu_size_bytes(size_i);
      mask     = (2*BE_W)'((1 << nbytes) - 1);
      // Shifting across a double-width window lets an access that crosses a
      // word boundary spill its upper bytes into the second beat.
      be_o     = mask << offset_i;
      wdata_o  = {{DATA_W{1'b0}}, wdata_i} << {offset_i, 3'b000};
      rd_shift = rdata_i >> {offset_i, 3'b000};
      raw      = rd_shift[DATA_W-1:0];
      // Shifting all-ones by >= DATA_W yields zero, so a full-width access keeps every bit.
      keep     = ~({DATA_W{1'b1}} << (nbytes * 8));
      case (size_i)
         LSU_SZ_B: sbit = raw[7];
         LSU_SZ_H: sbit = raw[15];
         LSU_SZ_W: sbit = raw[31];
         default:  sbit = raw[DATA_W-1];
      endcase
      rdata_o  = (raw & keep) | (~keep & {DATA_W{sbit & ~unsigned_i}});
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit between EX/MEM and a req/gnt/rvalid data bus, with split, timeout and flush.
// Latency: aligned 3 cycles, split 5 cycles, misalign exception 1 cycle (gnt immediate, rvalid one cycle later).
// Backpressure: req_ready_o only in IDLE; stall_o holds the pipeline while busy; bus request held until gnt.
// Ports: clk/rst (async, active-low); req_* request from MEM stage; flush_i discards the access;
//        bus_* data bus; resp_valid_o/wd_o/wreg_o/wdata_o write-back; exc_* exception report.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int SPLIT_MISALIGNED = 0,
   parameter int TIMEOUT_CYC      = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   input  logic [4:0]            req_wd_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  bus_req_o,
   input  logic                  bus_gnt_i,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W/8-1:0]   bus_be_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_err_i,
   output logic                  resp_valid_o,
   output logic [4:0]            wd_o,
   output logic                  wreg_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic                  exc_o,
   output logic [1:0]            exc_cause_o,
   output logic [ADDR_W-1:0]     exc_addr_o
);

   localparam int BE_W  = lsu_be_w(DATA_W);
   localparam int OFF_W = $clog2(BE_W);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   lsu_state_e          state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [4:0]          wd_q, wd_d;
   logic                exc_q, exc_d;
   logic [1:0]          cause_q, cause_d;
   logic                flushed_q, flushed_d;
   logic [2*DATA_W-1:0] asm_q, asm_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [2*BE_W-1:0]   be2;
   logic [2*DATA_W-1:0] wlane2;
   logic [DATA_W-1:0]   ld_data;
   logic                accept;
   logic                bad_size;
   logic                misal;
   logic                split;
   logic                tmo;
   logic                in_req;
   logic                in_bus;
   logic                kill;
   logic [ADDR_W-1:0]   addr_al;

   // Alignment works on latched fields so bus outputs stay stable while waiting for gnt.
   lsu_align #(.DATA_W(DATA_W)) u_align (
      .size_i     (size_q),
      .offset_i   (addr_q[OFF_W-1:0]),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .rdata_i    (asm_q),
      .be_o       (be2),
      .wdata_o    (wlane2),
      .rdata_o    (ld_data)
   );

   always_comb begin
      accept   = req_valid_i & req_ready_o;
      bad_size = lsu_size_illegal(req_size_i, DATA_W);
      misal    = lsu_misaligned(req_size_i, 3'(req_addr_i[OFF_W-1:0]));
      // A second beat is only needed when the bytes actually cross into the next word.
      split    = (SPLIT_MISALIGNED != 0) && (|be2[2*BE_W-1:BE_W]);
      tmo      = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      in_req   = (state_q == LSU_REQ) || (state_q == LSU_REQ2);
      in_bus   = in_req || (state_q == LSU_WAIT) || (state_q == LSU_WAIT2);
      kill     = flush_i | flushed_q;
      addr_al  = addr_q & ~ADDR_W'(BE_W - 1);
   end

   // Next state and request latch
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      uns_d     = uns_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wd_d      = wd_q;
      exc_d     = exc_q;
      cause_d   = cause_q;
      flushed_d = flushed_q;
      asm_d     = asm_q;
      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               we_d      = req_we_i;
               size_d    = req_size_i;
               uns_d     = req_unsigned_i;
               addr_d    = req_addr_i;
               wdata_d   = req_wdata_i;
               wd_d      = req_wd_i;
               asm_d     = '0;
               flushed_d = 1'b0;
               exc_d     = 1'b0;
               cause_d   = LSU_EXC_NONE;
               if (bad_size || (misal && (SPLIT_MISALIGNED == 0))) begin
                  exc_d   = 1'b1;
                  cause_d = req_we_i ? LSU_EXC_ST_MISALIGN : LSU_EXC_LD_MISALIGN;
                  state_d = LSU_RESP;
               end else begin
                  state_d = LSU_REQ;
               end
            end
         end
         LSU_REQ, LSU_REQ2: begin
            if (flush_i) begin
               state_d = LSU_IDLE;
            end else if (bus_gnt_i) begin
               state_d = (state_q == LSU_REQ) ? LSU_WAIT : LSU_WAIT2;
            end else if (tmo) begin
               exc_d   = 1'b1;
               cause_d = LSU_EXC_ACCESS;
               state_d = LSU_RESP;
            end
         end
         LSU_WAIT, LSU_WAIT2: begin
            // A granted beat must still be acknowledged, so a flush here only
            // marks the access as dead until the response arrives.
            if (flush_i) begin
               flushed_d = 1'b1;
            end
            if (bus_rvalid_i) begin
               if (kill) begin
                  state_d = LSU_IDLE;
               end else if (bus_err_i) begin
                  exc_d   = 1'b1;
                  cause_d = LSU_EXC_ACCESS;
                  state_d = LSU_RESP;
               end else if (state_q == LSU_WAIT) begin
                  asm_d[DATA_W-1:0] = bus_rdata_i;
                  state_d           = split ? LSU_REQ2 : LSU_RESP;
               end else begin
                  asm_d[2*DATA_W-1:DATA_W] = bus_rdata_i;
                  state_d                  = LSU_RESP;
               end
            end else if (tmo) begin
               if (kill) begin
                  state_d = LSU_IDLE;
               end else begin
                  exc_d   = 1'b1;
                  cause_d = LSU_EXC_ACCESS;
                  state_d = LSU_RESP;
               end
            end
         end
         LSU_RESP: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
      // Timeout counts cycles spent in the current bus state only.
      if ((state_d != state_q) || !in_bus) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LSU_IDLE;
         we_q      <= 1'b0;
         size_q    <= 2'd0;
         uns_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wd_q      <= 5'd0;
         exc_q     <= 1'b0;
         cause_q   <= 2'd0;
         flushed_q <= 1'b0;
         asm_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wd_q      <= wd_d;
         exc_q     <= exc_d;
         cause_q   <= cause_d;
         flushed_q <= flushed_d;
         asm_q     <= asm_d;
         cnt_q     <= cnt_d;
      end
   end

   // Outputs
   always_comb begin
      req_ready_o  = (state_q == LSU_IDLE) & ~flush_i;
      resp_valid_o = (state_q == LSU_RESP) & ~flush_i;
      stall_o      = (state_q != LSU_IDLE) & ~resp_valid_o;
      bus_req_o    = in_req & ~flush_i;
      bus_we_o     = 1'b0;
      bus_addr_o   = '0;
      bus_be_o     = '0;
      bus_wdata_o  = '0;
      if (state_q == LSU_REQ) begin
         bus_we_o    = we_q;
         bus_addr_o  = addr_al;
         bus_be_o    = be2[BE_W-1:0];
         bus_wdata_o = wlane2[DATA_W-1:0];
      end else if (state_q == LSU_REQ2) begin
         bus_we_o    = we_q;
         bus_addr_o  = addr_al + ADDR_W'(BE_W);
         bus_be_o    = be2[2*BE_W-1:BE_W];
         bus_wdata_o = wlane2[2*DATA_W-1:DATA_W];
      end
      wd_o        = resp_valid_o ? wd_q : 5'd0;
      wreg_o      = resp_valid_o & ~we_q & ~exc_q;
      wdata_o     = wreg_o ? ld_data : '0;
      exc_o       = resp_valid_o & exc_q;
      exc_cause_o = exc_o ? cause_q : 2'd0;
      exc_addr_o  = exc_o ? addr_q : '0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: instance A (no split, timeout 4) and instance B (split, timeout 4).
// Latency: cycle numbers count from the accepting clock edge.
// Backpressure: bench grants immediately except in the withheld-grant case.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_a, req_valid_b;
   logic        req_we, req_uns, flush;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, bus_rdata;
   logic [4:0]  req_wd;
   logic        bus_gnt, bus_rvalid, bus_err;

   logic        req_ready_a, stall_a, bus_req_a, bus_we_a, resp_valid_a, wreg_a, exc_a;
   logic [31:0] bus_addr_a, bus_wdata_a, wdata_a, exc_addr_a;
   logic [3:0]  bus_be_a;
   logic [4:0]  wd_a;
   logic [1:0]  exc_cause_a;
   logic        req_ready_b, stall_b, bus_req_b, bus_we_b, resp_valid_b, wreg_b, exc_b;
   logic [31:0] bus_addr_b, bus_wdata_b, wdata_b, exc_addr_b;
   logic [3:0]  bus_be_b;
   logic [4:0]  wd_b;
   logic [1:0]  exc_cause_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(0), .TIMEOUT_CYC(4)) u_dut_a (
      .clk(clk), .rst(rst_n), .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_wd_i(req_wd), .flush_i(flush), .stall_o(stall_a),
      .bus_req_o(bus_req_a), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we_a), .bus_addr_o(bus_addr_a),
      .bus_be_o(bus_be_a), .bus_wdata_o(bus_wdata_a), .bus_rvalid_i(bus_rvalid),
      .bus_rdata_i(bus_rdata), .bus_err_i(bus_err), .resp_valid_o(resp_valid_a), .wd_o(wd_a),
      .wreg_o(wreg_a), .wdata_o(wdata_a), .exc_o(exc_a), .exc_cause_o(exc_cause_a),
      .exc_addr_o(exc_addr_a));

   lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1), .TIMEOUT_CYC(4)) u_dut_b (
      .clk(clk), .rst(rst_n), .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_wd_i(req_wd), .flush_i(flush), .stall_o(stall_b),
      .bus_req_o(bus_req_b), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we_b), .bus_addr_o(bus_addr_b),
      .bus_be_o(bus_be_b), .bus_wdata_o(bus_wdata_b), .bus_rvalid_i(bus_rvalid),
      .bus_rdata_i(bus_rdata), .bus_err_i(bus_err), .resp_valid_o(resp_valid_b), .wd_o(wd_b),
      .wreg_o(wreg_b), .wdata_o(wdata_b), .exc_o(exc_b), .exc_cause_o(exc_cause_b),
      .exc_addr_o(exc_addr_b));

   // Selected-instance view used by the access task
   logic        sel_b;
   logic        x_bus_req, x_resp, x_wreg, x_exc;
   logic [31:0] x_addr, x_bwdat, x_wdata, x_eaddr;
   logic [3:0]  x_be;
   logic [4:0]  x_wd;
   logic [1:0]  x_cause;
   always_comb begin
      x_bus_req = sel_b ? bus_req_b    : bus_req_a;
      x_resp    = sel_b ? resp_valid_b : resp_valid_a;
      x_wreg    = sel_b ? wreg_b       : wreg_a;
      x_exc     = sel_b ? exc_b        : exc_a;
      x_addr    = sel_b ? bus_addr_b   : bus_addr_a;
      x_bwdat   = sel_b ? bus_wdata_b  : bus_wdata_a;
      x_wdata   = sel_b ? wdata_b      : wdata_a;
      x_eaddr   = sel_b ? exc_addr_b   : exc_addr_a;
      x_be      = sel_b ? bus_be_b     : bus_be_a;
      x_wd      = sel_b ? wd_b         : wd_a;
      x_cause   = sel_b ? exc_cause_b  : exc_cause_a;
   end

   // Results of the last access
   int          lat, nb;
   logic [31:0] b_addr [2];
   logic [31:0] b_wdat [2];
   logic [3:0]  b_be   [2];
   logic [31:0] r_wdata, r_eaddr;
   logic        r_wreg, r_exc;
   logic [1:0]  r_cause;
   logic [4:0]  r_wd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One access with immediate grant; rvalid follows each granted beat by one cycle.
   task automatic access(input bit use_b, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd0, input logic [31:0] rd1, input bit err);
      bit pend;
      sel_b       = use_b;
      req_we      = we;
      req_size    = sz;
      req_uns     = uns;
      req_addr    = addr;
      req_wdata   = wd;
      req_wd      = 5'd7;
      req_valid_a = !use_b;
      req_valid_b = use_b;
      bus_gnt     = 1'b1;
      lat         = -1;
      nb          = 0;
      pend        = 1'b0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         step();
         req_valid_a = 1'b0;
         req_valid_b = 1'b0;
         bus_rvalid  = 1'b0;
         bus_err     = 1'b0;
         if (pend) begin
            bus_rvalid = 1'b1;
            bus_rdata  = (nb == 1) ? rd0 : rd1;
            bus_err    = err;
            pend       = 1'b0;
         end
         if (x_bus_req) begin
            if (nb < 2) begin
               b_addr[nb] = x_addr;
               b_wdat[nb] = x_bwdat;
               b_be[nb]   = x_be;
            end
            nb++;
            pend = 1'b1;
         end
         if (x_resp) begin
            lat     = c;
            r_wdata = x_wdata;
            r_wreg  = x_wreg;
            r_exc   = x_exc;
            r_cause = x_cause;
            r_eaddr = x_eaddr;
            r_wd    = x_wd;
         end
      end
      bus_rvalid = 1'b0;
      bus_err    = 1'b0;
      bus_gnt    = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int reqcnt, respcnt;
      rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; flush = 1'b0;
      req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = '0; req_wdata = '0; req_wd = '0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0; sel_b = 1'b0;
      repeat (2) step();
      check("rst_ready", req_ready_a, 1);
      check("rst_stall", stall_a, 0);
      check("rst_busreq", bus_req_a, 0);
      check("rst_resp", resp_valid_a, 0);
      rst_n = 1'b1;
      step();

      // Aligned lw
      access(0, 0, 2'd2, 0, 32'h100, 0, 32'h8000_00F1, 0, 0);
      check("lw_lat", lat, 3);
      check("lw_addr", b_addr[0], 32'h100);
      check("lw_be", b_be[0], 4'hF);
      check("lw_wdata", r_wdata, 32'h8000_00F1);
      check("lw_wreg", r_wreg, 1);
      check("lw_wd", r_wd, 7);

      // lb / lbu at byte 3
      access(0, 0, 2'd0, 0, 32'h103, 0, 32'h80AA_BBCC, 0, 0);
      check("lb_be", b_be[0], 4'b1000);
      check("lb_addr", b_addr[0], 32'h100);
      check("lb_wdata", r_wdata, 32'hFFFF_FF80);
      access(0, 0, 2'd0, 1, 32'h103, 0, 32'h80AA_BBCC, 0, 0);
      check("lbu_wdata", r_wdata, 32'h0000_0080);

      // sh at 0x102
      access(0, 1, 2'd1, 0, 32'h102, 32'h1234, 0, 0, 0);
      check("sh_be", b_be[0], 4'b1100);
      check("sh_wdat_hi", b_wdat[0][31:16], 16'h1234);
      check("sh_wreg", r_wreg, 0);
      check("sh_exc", r_exc, 0);
      check("sh_lat", lat, 3);

      // Misaligned lw, no split
      access(0, 0, 2'd2, 0, 32'h101, 0, 0, 0, 0);
      check("mis_lat", lat, 1);
      check("mis_nbeats", nb, 0);
      check("mis_exc", r_exc, 1);
      check("mis_cause", r_cause, 1);
      check("mis_eaddr", r_eaddr, 32'h101);
      check("mis_wreg", r_wreg, 0);
      access(0, 1, 2'd1, 0, 32'h101, 32'h55, 0, 0, 0);
      check("smis_cause", r_cause, 2);

      // Split lw on instance B
      access(1, 0, 2'd2, 0, 32'h0FE, 0, 32'h4433_2211, 32'h8877_6655, 0);
      check("split_nbeats", nb, 2);
      check("split_addr0", b_addr[0], 32'h0FC);
      check("split_addr1", b_addr[1], 32'h100);
      check("split_be0", b_be[0], 4'b1100);
      check("split_be1", b_be[1], 4'b0011);
      check("split_wdata", r_wdata, 32'h6655_4433);
      check("split_lat", lat, 5);

      // Bus error
      access(0, 0, 2'd2, 0, 32'h200, 0, 32'hDEAD_BEEF, 0, 1);
      check("err_cause", r_cause, 3);
      check("err_wreg", r_wreg, 0);
      check("err_eaddr", r_eaddr, 32'h200);

      // Grant withheld: timeout after 4 cycles in REQ
      sel_b = 1'b0; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300; req_valid_a = 1'b1;
      bus_gnt = 1'b0; lat = -1; reqcnt = 0;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         step();
         req_valid_a = 1'b0;
         if (bus_req_a) reqcnt++;
         if (resp_valid_a) begin
            lat = c;
            r_cause = exc_cause_a;
            r_wreg  = wreg_a;
         end
      end
      check("tmo_lat", lat, 5);
      check("tmo_reqcycles", reqcnt, 4);
      check("tmo_cause", r_cause, 3);
      check("tmo_wreg", r_wreg, 0);
      step();

      // Flush in WAIT, response arrives afterwards
      req_addr = 32'h100; req_valid_a = 1'b1; bus_gnt = 1'b1; respcnt = 0;
      step();                                   // cycle 1: REQ, granted
      req_valid_a = 1'b0;
      step();                                   // cycle 2: WAIT
      bus_gnt = 1'b0; flush = 1'b1;
      if (resp_valid_a) respcnt++;
      step();                                   // cycle 3: still WAIT, flushed
      flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
      if (resp_valid_a) respcnt++;
      step();                                   // cycle 4: back in IDLE
      bus_rvalid = 1'b0;
      if (resp_valid_a) respcnt++;
      check("flush_ready", req_ready_a, 1);
      step();
      if (resp_valid_a) respcnt++;
      check("flush_noresp", respcnt, 0);

      // Flush coincident with request: not accepted
      req_valid_a = 1'b1; flush = 1'b1;
      step();
      req_valid_a = 1'b0; flush = 1'b0;
      check("flushacc_stall", stall_a, 0);
      check("flushacc_busreq", bus_req_a, 0);

      // Reset in WAIT
      req_valid_a = 1'b1; bus_gnt = 1'b1;
      step();
      req_valid_a = 1'b0;
      step();
      bus_gnt = 1'b0;
      check("prerst_stall", stall_a, 1);
      rst_n = 1'b0;
      #1;
      check("rst_wait_stall", stall_a, 0);
      check("rst_wait_resp", resp_valid_a, 0);
      check("rst_wait_ready", req_ready_a, 1);
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised multi-cycle load/store unit; next generation of the combinational mem-stage access logic.
- Sits between the EX/MEM pipeline register and the data bus.
- Drives a req/gnt/rvalid bus with byte enables; sign/zero-extends load data; detects misalignment; optionally splits misaligned accesses into two beats.
- Adds bus timeout, flush, and a stall to the pipeline.

Parameters:
- DATA_W, 32, bus/register width; 32 or 64 only.
- ADDR_W, 32, byte address width.
- SPLIT_MISALIGNED, 0, 1 = split misaligned access into two aligned beats; 0 = raise misalign exception.
- TIMEOUT_CYC, 255, max cycles in one wait state before access fault; 0 disables.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid_i  in  1  access request from MEM stage
- req_ready_o  out  1  unit idle, accepts request
- req_we_i  in  1  1 = store
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only, else illegal)
- req_unsigned_i  in  1  zero-extend load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  store data (reg2), right-justified
- req_wd_i  in  5  destination register
- flush_i  in  1  discard in-flight access
- stall_o  out  1  = busy & ~resp_valid_o
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word-aligned address
- bus_be_o  out  DATA_W/8  byte enables
- bus_wdata_o  out  DATA_W  lane-shifted store data
- bus_rvalid_i  in  1  response/ack (loads and stores)
- bus_rdata_i  in  DATA_W  read data
- bus_err_i  in  1  error, qualified by bus_rvalid_i
- resp_valid_o  out  1  one-cycle completion pulse
- wd_o  out  5  destination register
- wreg_o  out  1  write-back enable (load, no exception)
- wdata_o  out  DATA_W  extended load data
- exc_o  out  1  exception, with resp_valid_o
- exc_cause_o  out  2  1 = load misalign, 2 = store misalign, 3 = access fault
- exc_addr_o  out  ADDR_W  faulting byte address

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All outputs 0 except req_ready_o=1.
  - Timeout counter and beat registers cleared.
  - Reset mid-access abandons the access immediately; the bus side must tolerate a dropped request.
- States: IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
- IDLE: accept when req_valid_i & req_ready_o. Latch all request fields.
  - If misaligned or illegal size, and either SPLIT_MISALIGNED=0 or size illegal: go to RESP with exception; no bus traffic.
  - Otherwise go to REQ.
- REQ:
  - Drive bus_req_o=1, aligned address, bus_be_o = size mask shifted by addr offset (low beat only if split), and lane-shifted data.
  - Hold all bus outputs stable until bus_gnt_i; gnt sampled high moves to WAIT.
- WAIT:
  - On bus_rvalid_i, capture rdata into the low half of a 2*DATA_W assembly register.
  - If split, go to REQ2 (address + DATA_W/8, remaining byte enables). Otherwise go to RESP.
  - bus_err_i ends the access as an access fault; no second beat.
- REQ2/WAIT2: same as REQ/WAIT; capture into the high half, then go to RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then IDLE.
  - Load data = assembly register shifted right by offset, extended per size/unsigned.
  - wreg_o=0 on stores or exceptions.
- Latency with gnt at first request and rvalid on the cycle after gnt:
  - aligned: accept at cycle 0, resp_valid_o at cycle 3;
  - split: resp_valid_o at cycle 5;
  - misalign exception: resp_valid_o at cycle 1.
- Timeout: counter resets on each state entry. After TIMEOUT_CYC cycles in REQ/WAIT/REQ2/WAIT2, go to RESP with cause 3. A late rvalid is ignored while in IDLE.
- Flush:
  - In REQ/REQ2 before grant: drop bus_req_o, go to IDLE, no resp.
  - In WAIT/WAIT2: finish the bus handshake silently, then go to IDLE with no resp_valid_o.
  - In RESP: suppress resp_valid_o.
  - Flush in the same cycle as accept: request not accepted.
- exc_addr_o = original byte address.
- Partial writes to the second beat are not rolled back on a first-beat fault (first beat already faulted, so no second beat occurs).

Decomposition:
- Shared package/defines:
  - size encodings (LSU_SZ_B/H/W/D);
  - exception cause codes;
  - state encoding;
  - BE_W = DATA_W/8 constant.
- One natural sub-module, lsu_align: combinational byte-enable generation, store lane shifting, and load extraction/extension. Parametrised on DATA_W; reused by the cache later.

Test Plan:
- Aligned lw, addr 0x100, rdata 0x8000_00F1, gnt immediate, rvalid next cycle -> resp at cycle 3, wdata_o=0x8000_00F1, wreg_o=1.
- lb at 0x103 with rdata 0x80AA_BBCC -> bus_be_o=4'b1000, wdata_o=0xFFFF_FF80; lbu -> 0x0000_0080.
- sh 0x1234 at 0x102 -> bus_be_o=4'b1100, bus_wdata_o=0x1234_xxxx, wreg_o=0; lw at 0x101 with SPLIT=0 -> resp cycle 1, exc_cause_o=1, exc_addr_o=0x101, no bus_req_o.
- SPLIT=1, lw at 0x0FE, beats 0x4433_2211 then 0x8877_6655 -> bus addrs 0x0FC/0x100, be 4'b1100/4'b0011, wdata_o=0x6655_4433, resp at cycle 5.
- gnt withheld, TIMEOUT_CYC=4 -> resp with exc_cause_o=3 after 4 cycles in REQ; bus_err_i on rvalid -> cause 3, wreg_o=0.
- flush_i in WAIT, then rvalid -> no resp_valid_o, req_ready_o=1 next cycle; rst low mid-WAIT -> all outputs 0 immediately.
